seq_detect_ctrl: RTL
====================

// Module: seq_detect_ctrl
// PURPOSE
//  Run controller for the bit-serial sequence detectors. Accepts a programmable pattern
//  (1..MAXLEN bits), overlap mode and match target over a config handshake.
//  Arms on start, detects on serial input A, pulses Y per match and counts matches.
//  Stops at the target or on stop. Replaces per-pattern hard-coded Moore FSMs in the sequence-detector designs.
// PARAMETERS
//  MAXLEN  8  longest supported pattern, bits
//  CW      8  width of match counter and target
//  LW      localparam $clog2(MAXLEN+1), width of cfg_len
// PORTS
//  clk          in   1       single clock, all state updates on rising edge
//  reset        in   1       synchronous, active-high
//  cfg_valid    in   1       config offered this cycle
//  cfg_ready    out  1       config accepted when cfg_valid & cfg_ready
//  cfg_pattern  in   MAXLEN  pattern; pattern[cfg_len-1] is the first bit received
//  cfg_len      in   LW      pattern length, legal 1..MAXLEN
//  cfg_overlap  in   1       1 = overlapping matches, 0 = history cleared after each match
//  cfg_target   in   CW      match count that ends the run; 0 = run until stop
//  cfg_err      out  1       1-cycle pulse: config handshake with illegal cfg_len, config not taken
//  start        in   1       begin run (level sampled per cycle)
//  stop         in   1       abort run
//  A            in   1       serial input, sampled every clk edge while RUN
//  Y            out  1       registered match pulse
//  busy         out  1       1 in RUN
//  done         out  1       1 in DONE
//  match_count  out  CW      matches in current run, saturates at 2^CW-1
// BEHAVIOUR
//  Reset: state=IDLE; Y=0, busy=0, done=0, cfg_err=0, match_count=0, cfg_ready=1.
//   Stored config is cleared (loaded=0) and history/fill are cleared.
//  States: IDLE, ARMED, RUN, DONE. cfg_ready = (state==IDLE || state==DONE).
//  IDLE/DONE + handshake, legal len: latch config, loaded=1, go ARMED. match_count holds until start.
//  IDLE/DONE + handshake, len==0 or >MAXLEN: cfg_err=1 for one cycle; state and stored config unchanged.
//  Handshake while ARMED or RUN is impossible (cfg_ready=0); cfg_valid is ignored.
//  start with loaded=1 from ARMED or DONE: clear match_count, history and fill; go RUN.
//   start in IDLE (loaded=0) is ignored.
//  RUN, each edge: hist <= {hist[MAXLEN-2:0],A}; fill <= min(fill+1,MAXLEN).
//   Match = (fill_next >= len) && hist_next[len-1:0] == pattern[len-1:0].
//  On match: Y=1 for exactly the next cycle (Moore-style, latency 1 clk after the final bit's edge).
//   match_count increments, saturating.
//   Non-overlap: fill <= 0 on the same edge, so a new match needs len fresh bits.
//  Target: when cfg_target!=0 and match_count reaches cfg_target on a match edge, go DONE on that edge.
//   The Y pulse still occurs; no further bits are sampled.
//  stop in RUN: go ARMED; match_count holds; Y from a match on that same edge is suppressed.
//   stop has priority over start and over a target hit.
//  stop outside RUN: ignored. start in RUN: ignored.
//  Reset mid-run: immediate return to reset values; no Y pulse emitted.
//  Width: counters wrap never (saturate); len compare uses LW-bit unsigned.
// STRUCTURE
//  Package seq_ctrl_pkg:
//   typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} seq_state_t;
//   MAXLEN_DEF and CW_DEF constants.
//  Sub-module seq_match_core: history shift register, fill counter and masked comparator.
//   Outputs a combinational match_next signal; the top holds the FSM, counter, handshake and Y register.
// TESTING
//  1 Config 111/len3/overlap/target0, start; A=0,0,1,1,1,1,0 -> Y pulses after the 5th and 6th bits; count=2.
//  2 Same stream with non-overlap -> single Y pulse after the 5th bit; count=1.
//  3 Pattern 1011/len4/overlap, target=2; A=1,0,1,1,0,1,1 -> Y after bits 4 and 7; done=1 on the 2nd match edge.
//    Further A toggles -> no Y.
//  4 cfg_len=0 and cfg_len=9 -> cfg_err single pulse, state IDLE, start ignored.
//    Legal config next -> ARMED.
//  5 stop and start asserted together in RUN, on the edge completing a match -> ARMED, Y stays 0, count held.
//  6 reset asserted mid-RUN after 2 matches -> next cycle all outputs 0, cfg_ready=1; start ignored until reconfigured.

Source files
------------

// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and defaults for the serial sequence-detector run controller.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int MAXLEN_DEF = 8;
    localparam int CW_DEF     = 8;

    // Width needed to hold a pattern length of 0..maxlen.
    function automatic int len_w(input int maxlen);
        return $clog2(maxlen + 1);
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Config handshake, run control, serial input and status bundle of the controller.
interface seq_detect_ctrl_if import seq_ctrl_pkg::*; #(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int CW     = CW_DEF
);
    localparam int LW = len_w(MAXLEN);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LW-1:0]     cfg_len;
    logic              cfg_overlap;
    logic [CW-1:0]     cfg_target;
    logic              cfg_err;
    logic              start;
    logic              stop;
    logic              A;
    logic              Y;
    logic              busy;
    logic              done;
    logic [CW-1:0]     match_count;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, stop, A,
        input  cfg_ready, cfg_err, Y, busy, done, match_count
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, stop, A,
        output cfg_ready, cfg_err, Y, busy, done, match_count
    );

endinterface

// File: rtl/seq_detect_ctrl_match_core.sv
// History shift register, fill counter and masked pattern compare; match_next_o is
// combinational for the bit on A this cycle. State is held clear whenever run_i is low.
module seq_match_core import seq_ctrl_pkg::*; #(
    parameter  int MAXLEN = MAXLEN_DEF,
    localparam int LW     = len_w(MAXLEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic              a_i,
    input  logic [MAXLEN-1:0] pattern_i,
    input  logic [LW-1:0]     len_i,
    input  logic              overlap_i,
    output logic              match_next_o
);

    localparam logic [LW-1:0] FILL_MAX = LW'(MAXLEN);

    logic [MAXLEN-1:0] hist_q, hist_d;
    logic [MAXLEN-1:0] mask;
    logic [LW-1:0]     fill_q, fill_d;
    logic              hit;

    always_comb begin
        hist_d = {hist_q[MAXLEN-2:0], a_i};
        fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
        mask   = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (i < int'(len_i));
        end
        hit = (fill_d >= len_i) && ((hist_d & mask) == (pattern_i & mask));
    end

    assign match_next_o = run_i && hit;

    always_ff @(posedge clk) begin
        if (reset || !run_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            // Non-overlap mode demands len fresh bits before the next match.
            fill_q <= (hit && !overlap_i) ? '0 : fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: config handshake, IDLE/ARMED/RUN/DONE FSM, saturating match counter.
// Y pulses one cycle after the edge that samples a match's final bit; cfg_ready only in IDLE/DONE.
module seq_detect_ctrl import seq_ctrl_pkg::*; #(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int CW     = CW_DEF
) (
    input logic              clk,
    input logic              reset,
    seq_detect_ctrl_if.slave bus
);

    localparam int              LW      = len_w(MAXLEN);
    localparam logic [LW-1:0]   LEN_MAX = LW'(MAXLEN);
    localparam logic [CW-1:0]   CNT_MAX = '1;

    seq_state_t        state_q;
    logic              loaded_q;
    logic [MAXLEN-1:0] pattern_q;
    logic [LW-1:0]     len_q;
    logic              overlap_q;
    logic [CW-1:0]     target_q;
    logic              y_q;
    logic              cfg_err_q;
    logic [CW-1:0]     count_q, count_d;

    logic cfg_open, cfg_take, len_ok, run_go, match_next, target_hit;

    assign cfg_open   = (state_q == IDLE) || (state_q == DONE);
    assign cfg_take   = cfg_open && bus.cfg_valid;
    assign len_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);
    assign run_go     = bus.start && loaded_q;
    assign count_d    = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    assign target_hit = (target_q != '0) && (count_d == target_q);

    seq_match_core #(.MAXLEN(MAXLEN)) u_core (
        .clk          (clk),
        .reset        (reset),
        .run_i        (state_q == RUN),
        .a_i          (bus.A),
        .pattern_i    (pattern_q),
        .len_i        (len_q),
        .overlap_i    (overlap_q),
        .match_next_o (match_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            loaded_q  <= 1'b0;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            y_q       <= 1'b0;
            cfg_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            y_q       <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (cfg_take) begin
                        if (len_ok) begin
                            pattern_q <= bus.cfg_pattern;
                            len_q     <= bus.cfg_len;
                            overlap_q <= bus.cfg_overlap;
                            target_q  <= bus.cfg_target;
                            loaded_q  <= 1'b1;
                            state_q   <= ARMED;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end else if (run_go) begin
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                ARMED: begin
                    if (run_go) begin
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // stop wins over a match or target hit on the same edge.
                    if (bus.stop) begin
                        state_q <= ARMED;
                    end else if (match_next) begin
                        y_q     <= 1'b1;
                        count_q <= count_d;
                        if (target_hit) begin
                            state_q <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cfg_ready   = cfg_open;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.Y           = y_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.match_count = count_q;

endmodule
